// File: rtl/m_level_pkg.sv
// rtl/m_level_pkg.sv - shared MIPS opcode/funct codes, select encodings and M-stage decode
package m_level_pkg;

  localparam int DM_WORDS_DEF = 3072;
  localparam int DM_AW_DEF    = 12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  // Destination register select
  typedef enum logic [1:0] {A3_NONE, A3_RD, A3_RT, A3_RA} grfa3_e;
  // Write-data source select
  typedef enum logic [1:0] {WD_ALU, WD_PC8, WD_DM} grfwd_e;
  // Load/store access width
  typedef enum logic [1:0] {LS_WORD, LS_HALF, LS_BYTE} ls_width_e;

  typedef struct packed {
    grfa3_e    a3_sel;
    grfwd_e    wd_sel;
    logic      load;
    logic      store;
    ls_width_e width;
    logic      sext;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] ir);
    ctrl_t c;
    c = '0;
    case (ir[31:26])
      OP_RTYPE: begin
        if (ir[5:0] == FN_JALR) begin
          c.a3_sel = A3_RD;
          c.wd_sel = WD_PC8;
        end else if (ir[5:0] != FN_JR) begin
          c.a3_sel = A3_RD;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: c.a3_sel = A3_RT;
      OP_JAL: begin
        c.a3_sel = A3_RA;
        c.wd_sel = WD_PC8;
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        c.a3_sel = A3_RT;
        c.wd_sel = WD_DM;
        c.load   = 1'b1;
        c.sext   = (ir[31:26] == OP_LB) || (ir[31:26] == OP_LH);
        c.width  = (ir[31:26] == OP_LW) ? LS_WORD :
                   ((ir[31:26] == OP_LH) || (ir[31:26] == OP_LHU)) ? LS_HALF : LS_BYTE;
      end
      OP_SB, OP_SH, OP_SW: begin
        c.store = 1'b1;
        c.width = (ir[31:26] == OP_SW) ? LS_WORD :
                  (ir[31:26] == OP_SH) ? LS_HALF : LS_BYTE;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/m_level_if.sv
// rtl/m_level_if.sv - W-to-M and M-to-D/E forwarding bundle
interface m_level_if;
  logic [4:0]  W_RFA3_in;
  logic [31:0] W_RFWD_in;
  logic        W_RFWr_in;
  logic        W_Forward_Ready_in;
  logic [4:0]  M_RFA3_out;
  logic [31:0] M_RFWD_out;
  logic        M_RFWr_out;
  logic        M_Forward_Ready_out;

  modport master (
    output W_RFA3_in, W_RFWD_in, W_RFWr_in, W_Forward_Ready_in,
    input  M_RFA3_out, M_RFWD_out, M_RFWr_out, M_Forward_Ready_out
  );

  modport slave (
    input  W_RFA3_in, W_RFWD_in, W_RFWr_in, W_Forward_Ready_in,
    output M_RFA3_out, M_RFWD_out, M_RFWr_out, M_Forward_Ready_out
  );
endinterface

// File: rtl/m_level_dm.sv
// rtl/m_level_dm.sv - word-organised data memory with byte-lane stores and extending loads
module m_dm
  import m_level_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = DM_AW_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_store,
  input  logic        i_load,
  input  ls_width_e   i_width,
  input  logic        i_sext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_pc,
  output logic [31:0] o_rdata
);

  // A word whose valid bit is clear reads as zero, so reset clears the whole
  // array in one edge without touching the storage itself.
  logic [31:0]         r_mem [DM_WORDS];
  logic [DM_WORDS-1:0] r_valid;

  logic [DM_AW-1:0] w_widx;
  logic             w_in_range;
  logic [31:0]      w_old;
  logic [31:0]      w_lanes;
  logic [31:0]      w_new;
  logic [3:0]       w_be;
  logic [31:0]      w_bshift;
  logic [31:0]      w_hshift;

  assign w_widx     = i_addr[DM_AW+1:2];
  assign w_in_range = (int'(w_widx) < DM_WORDS);
  assign w_old      = (w_in_range && r_valid[w_widx]) ? r_mem[w_widx] : '0;
  assign w_bshift   = w_old >> {i_addr[1:0], 3'b000};
  assign w_hshift   = w_old >> {i_addr[1], 4'b0000};

  // Byte enables and replicated store data for the selected lane
  always_comb begin
    w_be    = '0;
    w_lanes = '0;
    case (i_width)
      LS_WORD: begin
        w_be    = 4'b1111;
        w_lanes = i_wdata;
      end
      LS_HALF: begin
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{i_wdata[15:0]}};
      end
      LS_BYTE: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_lanes = {4{i_wdata[7:0]}};
      end
      default: begin
        w_be    = '0;
        w_lanes = '0;
      end
    endcase
  end

  // Merge the enabled lanes into the current word
  always_comb begin
    w_new = w_old;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_new[8*b +: 8] = w_lanes[8*b +: 8];
    end
  end

  // Lane extraction and sign/zero extension for loads
  always_comb begin
    o_rdata = '0;
    if (i_load) begin
      case (i_width)
        LS_WORD: o_rdata = w_old;
        LS_HALF: o_rdata = {{16{i_sext & w_hshift[15]}}, w_hshift[15:0]};
        LS_BYTE: o_rdata = {{24{i_sext & w_bshift[7]}}, w_bshift[7:0]};
        default: o_rdata = '0;
      endcase
    end
  end

  // Store commit; reset wins over a store in flight, out-of-range writes drop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_store && w_in_range) begin
      r_mem[w_widx]   <= w_new;
      r_valid[w_widx] <= 1'b1;
`ifndef SYNTHESIS
      $display("@%h: *%h <= %h", i_pc, {i_addr[31:2], 2'b00}, w_new);
`endif
    end
  end

endmodule

// File: rtl/m_level.sv
// rtl/m_level.sv - MIPS M stage: pipeline register, forwarding publish, data memory access
module m_level
  import m_level_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = DM_AW_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Reg_Rst,
  input  logic        We,
  input  logic [31:0] IR_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] Y_in,
  input  logic [31:0] V2_in,
  m_level_if.slave    fwd,
  output logic [31:0] IR_out,
  output logic [31:0] PC_out,
  output logic [31:0] Y_out,
  output logic [31:0] DR_out
);

  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic [31:0] r_y;
  logic [31:0] r_v2;

  ctrl_t       w_ctrl;
  logic [4:0]  w_rt;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic [31:0] w_st_data;

  // M pipeline register; a cleared IR is a nop
  always_ff @(posedge Clk) begin
    if (Rst || Reg_Rst) begin
      r_ir <= '0;
      r_pc <= '0;
      r_y  <= '0;
      r_v2 <= '0;
    end else if (We) begin
      r_ir <= IR_in;
      r_pc <= PC_in;
      r_y  <= Y_in;
      r_v2 <= V2_in;
    end
  end

  assign w_ctrl = decode(r_ir);
  assign w_rt   = r_ir[20:16];

  // Destination and forwardable value; non-writers publish all zeros
  always_comb begin
    w_a3 = '0;
    case (w_ctrl.a3_sel)
      A3_RD:   w_a3 = r_ir[15:11];
      A3_RT:   w_a3 = w_rt;
      A3_RA:   w_a3 = 5'd31;
      default: w_a3 = '0;
    endcase
    w_wd = '0;
    if (w_a3 != '0) begin
      case (w_ctrl.wd_sel)
        WD_PC8:  w_wd = r_pc + 32'd8;
        WD_ALU:  w_wd = r_y;
        default: w_wd = '0;
      endcase
    end
  end

  // Store data: late forward from W covers a load immediately followed by a store of it
  always_comb begin
    w_st_data = r_v2;
    if (w_rt == '0) begin
      w_st_data = '0;
    end else if (w_rt == fwd.W_RFA3_in && fwd.W_RFWr_in && fwd.W_Forward_Ready_in) begin
      w_st_data = fwd.W_RFWD_in;
    end
  end

  assign fwd.M_RFA3_out          = w_a3;
  assign fwd.M_RFWr_out          = (w_a3 != '0);
  assign fwd.M_RFWD_out          = w_wd;
  assign fwd.M_Forward_Ready_out = (w_a3 != '0) && (w_ctrl.wd_sel != WD_DM);

  assign IR_out = r_ir;
  assign PC_out = r_pc;
  assign Y_out  = r_y;

  m_dm #(
    .DM_WORDS (DM_WORDS),
    .DM_AW    (DM_AW)
  ) u_dm (
    .i_clk   (Clk),
    .i_rst   (Rst),
    .i_store (w_ctrl.store),
    .i_load  (w_ctrl.load),
    .i_width (w_ctrl.width),
    .i_sext  (w_ctrl.sext),
    .i_addr  (r_y),
    .i_wdata (w_st_data),
    .i_pc    (r_pc),
    .o_rdata (DR_out)
  );

endmodule

// File: tb/tb_m_level.sv
// tb/tb_m_level.sv - self-checking bench for the M stage
module tb_m_level;
  import m_level_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst, Reg_Rst, We;
  logic [31:0] IR_in, PC_in, Y_in, V2_in;
  logic [31:0] IR_out, PC_out, Y_out, DR_out;

  m_level_if fwd();

  m_level dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Reg_Rst (Reg_Rst),
    .We      (We),
    .IR_in   (IR_in),
    .PC_in   (PC_in),
    .Y_in    (Y_in),
    .V2_in   (V2_in),
    .fwd     (fwd),
    .IR_out  (IR_out),
    .PC_out  (PC_out),
    .Y_out   (Y_out),
    .DR_out  (DR_out)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Byte-addressed little-endian reference memory; 0x3000 and above is unmapped
  logic [7:0] ref_mem [DM_WORDS_DEF*4];

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] y;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        wr;
    logic        rdy;
  } vec_t;

  vec_t       vecs [14];
  logic [5:0] ops  [8];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input int a);
    logic [15:0] h;
    logic [7:0]  b;
    int          w;
    if (a >= 32'h3000) return 32'h0;
    w = a & ~3;
    h = {ref_mem[(a & ~1) + 1], ref_mem[a & ~1]};
    b = ref_mem[a];
    case (op)
      OP_LW:   return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      OP_LB:   return {{24{b[7]}}, b};
      default: return {24'h0, b};
    endcase
  endfunction

  task automatic ref_store(input logic [5:0] op, input int a, input logic [31:0] d);
    int w;
    if (a >= 32'h3000) return;
    if (op == OP_SW) begin
      w = a & ~3;
      for (int k = 0; k < 4; k++) ref_mem[w+k] = d[8*k +: 8];
    end else if (op == OP_SH) begin
      w = a & ~1;
      ref_mem[w]   = d[7:0];
      ref_mem[w+1] = d[15:8];
    end else begin
      ref_mem[a] = d[7:0];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] y, input logic [31:0] v2);
    IR_in = ir; PC_in = pc; Y_in = y; V2_in = v2;
    We = 1'b1; Rst = 1'b0; Reg_Rst = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic set_w(input logic [4:0] a3, input logic [31:0] wd,
                       input logic wr, input logic rdy);
    fwd.W_RFA3_in = a3; fwd.W_RFWD_in = wd;
    fwd.W_RFWr_in = wr; fwd.W_Forward_Ready_in = rdy;
    #1;
  endtask

  task automatic do_reset();
    IR_in = enc_i(OP_SW, 5'd0, 5'd9, 16'h40); PC_in = 32'h3ffc; Y_in = 32'h40; V2_in = 32'h99;
    We = 1'b1; Rst = 1'b1; Reg_Rst = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  task automatic chk_fwd(input string name, input logic [4:0] a3, input logic [31:0] wd,
                         input logic wr, input logic rdy);
    chk({name, "_a3"},  {27'h0, fwd.M_RFA3_out}, {27'h0, a3});
    chk({name, "_wd"},  fwd.M_RFWD_out, wd);
    chk({name, "_wr"},  {31'h0, fwd.M_RFWr_out}, {31'h0, wr});
    chk({name, "_rdy"}, {31'h0, fwd.M_Forward_Ready_out}, {31'h0, rdy});
  endtask

  initial begin
    Rst = 1'b1; Reg_Rst = 1'b0; We = 1'b0;
    IR_in = '0; PC_in = '0; Y_in = '0; V2_in = '0;
    set_w(5'd0, 32'h0, 1'b0, 1'b0);

    vecs[0]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h21),  32'h3000, 32'h11111111, 5'd3,  32'h11111111, 1'b1, 1'b1};
    vecs[1]  = '{enc_i(OP_ORI, 5'd5, 5'd4, 16'h1), 32'h3004, 32'h00000abc, 5'd4,  32'h00000abc, 1'b1, 1'b1};
    vecs[2]  = '{enc_i(OP_LUI, 5'd0, 5'd7, 16'h1234), 32'h3008, 32'h12340000, 5'd7, 32'h12340000, 1'b1, 1'b1};
    vecs[3]  = '{enc_i(OP_LW, 5'd0, 5'd8, 16'h4),  32'h300c, 32'h4,        5'd8,  32'h0,        1'b1, 1'b0};
    vecs[4]  = '{{OP_JAL, 26'h100},                32'h3000, 32'h0,        5'd31, 32'h3008,     1'b1, 1'b1};
    vecs[5]  = '{enc_r(5'd10, 5'd0, 5'd9, FN_JALR), 32'h3100, 32'h0,       5'd9,  32'h3108,     1'b1, 1'b1};
    vecs[6]  = '{enc_r(5'd31, 5'd0, 5'd0, FN_JR),  32'h3104, 32'h5,        5'd0,  32'h0,        1'b0, 1'b0};
    vecs[7]  = '{enc_i(OP_BEQ, 5'd1, 5'd2, 16'h3), 32'h3108, 32'h7,        5'd0,  32'h0,        1'b0, 1'b0};
    vecs[8]  = '{enc_i(OP_SW, 5'd0, 5'd2, 16'h40), 32'h310c, 32'h40,       5'd0,  32'h0,        1'b0, 1'b0};
    vecs[9]  = '{enc_r(5'd1, 5'd2, 5'd0, 6'h21),   32'h3110, 32'h55,       5'd0,  32'h0,        1'b0, 1'b0};
    vecs[10] = '{32'h0,                            32'h3114, 32'h0,        5'd0,  32'h0,        1'b0, 1'b0};
    vecs[11] = '{enc_i(OP_ADDIU, 5'd0, 5'd31, 16'h5), 32'h3118, 32'h5,     5'd31, 32'h5,        1'b1, 1'b1};
    vecs[12] = '{enc_i(OP_LBU, 5'd1, 5'd6, 16'h0), 32'h311c, 32'h8,        5'd6,  32'h0,        1'b1, 1'b0};
    vecs[13] = '{{OP_J, 26'h200},                  32'h3120, 32'h9,        5'd0,  32'h0,        1'b0, 1'b0};

    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    // Reset state
    do_reset();
    chk("rst_ir", IR_out, 32'h0);
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_y",  Y_out,  32'h0);
    chk("rst_dr", DR_out, 32'h0);
    chk_fwd("rst", 5'd0, 32'h0, 1'b0, 1'b0);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h0), 32'h3000, 32'h0, 32'h0);
    chk("rst_lw0", DR_out, 32'h0);

    // Decode / forwarding table
    foreach (vecs[i]) begin
      issue(vecs[i].ir, vecs[i].pc, vecs[i].y, 32'h0);
      chk("tbl_ir", IR_out, vecs[i].ir);
      chk("tbl_pc", PC_out, vecs[i].pc);
      chk("tbl_y",  Y_out,  vecs[i].y);
      chk_fwd("tbl", vecs[i].a3, vecs[i].wd, vecs[i].wr, vecs[i].rdy);
    end

    // Word store then load
    do_reset();
    issue(enc_i(OP_SW, 5'd0, 5'd9, 16'h10), 32'h3000, 32'h10, 32'h12345678);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h10), 32'h3004, 32'h10, 32'h0);
    chk("sw_lw", DR_out, 32'h12345678);

    // Byte store over existing word, signed and unsigned byte loads
    issue(enc_i(OP_SB, 5'd0, 5'd9, 16'h13), 32'h3008, 32'h13, 32'h000000f0);
    issue(enc_i(OP_LB, 5'd0, 5'd8, 16'h13), 32'h300c, 32'h13, 32'h0);
    chk("sb_lb", DR_out, 32'hfffffff0);
    issue(enc_i(OP_LBU, 5'd0, 5'd8, 16'h13), 32'h3010, 32'h13, 32'h0);
    chk("sb_lbu", DR_out, 32'h000000f0);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h10), 32'h3014, 32'h10, 32'h0);
    chk("sb_word", DR_out, 32'hf0345678);

    // Halfword store on a zeroed word
    do_reset();
    issue(enc_i(OP_SH, 5'd0, 5'd9, 16'h12), 32'h3000, 32'h12, 32'h0000abcd);
    issue(enc_i(OP_LH, 5'd0, 5'd8, 16'h12), 32'h3004, 32'h12, 32'h0);
    chk("sh_lh", DR_out, 32'hffffabcd);
    issue(enc_i(OP_LHU, 5'd0, 5'd8, 16'h10), 32'h3008, 32'h10, 32'h0);
    chk("sh_lhu_lo", DR_out, 32'h00000000);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h10), 32'h300c, 32'h10, 32'h0);
    chk("sh_word", DR_out, 32'habcd0000);

    // Store data forwarded from W, not forwarded when W is not ready, and $0
    issue(enc_i(OP_SW, 5'd0, 5'd5, 16'h20), 32'h3010, 32'h20, 32'h0);
    set_w(5'd5, 32'hdeadbeef, 1'b1, 1'b1);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h20), 32'h3014, 32'h20, 32'h0);
    set_w(5'd0, 32'h0, 1'b0, 1'b0);
    chk("fwd_w", DR_out, 32'hdeadbeef);
    issue(enc_i(OP_SW, 5'd0, 5'd5, 16'h20), 32'h3018, 32'h20, 32'h11112222);
    set_w(5'd5, 32'hdeadbeef, 1'b1, 1'b0);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h20), 32'h301c, 32'h20, 32'h0);
    set_w(5'd0, 32'h0, 1'b0, 1'b0);
    chk("fwd_notrdy", DR_out, 32'h11112222);
    issue(enc_i(OP_SW, 5'd0, 5'd0, 16'h20), 32'h3020, 32'h20, 32'h5555aaaa);
    set_w(5'd0, 32'hdeadbeef, 1'b1, 1'b1);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h20), 32'h3024, 32'h20, 32'h0);
    set_w(5'd0, 32'h0, 1'b0, 1'b0);
    chk("fwd_r0", DR_out, 32'h0);

    // Top-of-memory boundary: last word stores, first unmapped word drops
    issue(enc_i(OP_SW, 5'd0, 5'd9, 16'h2ffc), 32'h3028, 32'h2ffc, 32'hcafef00d);
    issue(enc_i(OP_SW, 5'd0, 5'd9, 16'h3000), 32'h302c, 32'h3000, 32'h01020304);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h2ffc), 32'h3030, 32'h2ffc, 32'h0);
    chk("bnd_last", DR_out, 32'hcafef00d);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h3000), 32'h3034, 32'h3000, 32'h0);
    chk("bnd_over", DR_out, 32'h0);

    // jal forwarding, then Reg_Rst with a store in M
    issue({OP_JAL, 26'h0c00}, 32'h3000, 32'h0, 32'h0);
    chk_fwd("jal", 5'd31, 32'h3008, 1'b1, 1'b1);
    issue(enc_i(OP_SW, 5'd0, 5'd9, 16'h30), 32'h3004, 32'h30, 32'h55aa55aa);
    IR_in = enc_r(5'd1, 5'd2, 5'd3, 6'h21); Y_in = 32'h77; Reg_Rst = 1'b1;
    @(posedge Clk); #1;
    Reg_Rst = 1'b0;
    chk("rrst_ir", IR_out, 32'h0);
    chk("rrst_y",  Y_out,  32'h0);
    chk_fwd("rrst", 5'd0, 32'h0, 1'b0, 1'b0);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h30), 32'h3008, 32'h30, 32'h0);
    chk("rrst_store", DR_out, 32'h55aa55aa);

    // We low holds the register
    issue(enc_r(5'd1, 5'd2, 5'd3, 6'h21), 32'h3010, 32'h77, 32'h0);
    IR_in = enc_i(OP_ORI, 5'd0, 5'd4, 16'h1); Y_in = 32'h99; We = 1'b0;
    @(posedge Clk); #1;
    chk("hold_ir", IR_out, enc_r(5'd1, 5'd2, 5'd3, 6'h21));
    chk("hold_y",  Y_out,  32'h77);

    // Rst clears memory and suppresses the store in M
    do_reset();
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h30), 32'h3000, 32'h30, 32'h0);
    chk("rst_clr", DR_out, 32'h0);
    issue(enc_i(OP_LW, 5'd0, 5'd8, 16'h40), 32'h3004, 32'h40, 32'h0);
    chk("rst_sup", DR_out, 32'h0);

    // Randomized loads/stores against the byte-level reference
    do_reset();
    foreach (ref_mem[k]) ref_mem[k] = 8'h0;
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  op;
      int          a;
      logic [4:0]  rt, wa3;
      logic [31:0] v2, wd, sd;
      logic        wwr, wrdy;
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) == 0) a = int'($urandom_range(32'h2fe0, 32'h301f));
      else                           a = int'($urandom_range(0, 127));
      rt = 5'($urandom_range(0, 31));
      v2 = $urandom;
      issue(enc_i(op, 5'($urandom_range(0, 31)), rt, 16'(a)), 32'h3000 + 32'(4*i), 32'(a), v2);
      wa3  = ($urandom_range(0, 1) == 1) ? rt : 5'($urandom_range(0, 31));
      wd   = $urandom;
      wwr  = 1'($urandom_range(0, 1));
      wrdy = 1'($urandom_range(0, 1));
      set_w(wa3, wd, wwr, wrdy);
      if (op == OP_SB || op == OP_SH || op == OP_SW) begin
        if (rt == 5'd0)                      sd = 32'h0;
        else if (wa3 == rt && wwr && wrdy)   sd = wd;
        else                                 sd = v2;
        ref_store(op, a, sd);
      end else begin
        chk("rnd_dr", DR_out, ref_load(op, a));
        chk_fwd("rnd_ld", rt, 32'h0, rt != 5'd0, 1'b0);
      end
    end
    issue(32'h0, 32'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
